rs_syndrome_ctrl: RTL and testbench

Sequencer for the syndrome stage of the RS(15,11) decoder over GF(16). It accepts one received codeword as 15 serial 4-bit symbols over a valid/ready handshake and runs four Horner accumulators, S_j <= S_j*alpha^j XOR r, for j = 1..4. At end of frame it presents S1..S4 and an error-detect flag to the downstream key-equation stage and holds them until accepted. It sits between the symbol input interface and the Berlekamp-Massey/Chien blocks.

---
 rtl/rs_gf16_pkg.sv | 28 ++
 rtl/gf_mult_alpha_pow.sv | 19 +
 rtl/rs_syndrome_ctrl.sv | 117 +++++++++++
 tb/tb_rs_syndrome_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_gf16_pkg.sv
// Shared GF(16) constants, helpers and controller state type for the RS(15,11) syndrome stage.
package rs_gf16_pkg;

    // Reduction taps of x^4 + x + 1 (x^4 folds back to x + 1).
    localparam logic [3:0] GF_POLY = 4'b0011;

    localparam int unsigned SYM_W = 4;
    localparam int unsigned N_SYM = 15;
    localparam int unsigned N_SYN = 4;

    // alpha^i for i = 0..14, handy reference for anyone checking syndrome values.
    localparam logic [3:0] ALPHA_POW [0:14] = '{
        4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd6, 4'd12, 4'd11,
        4'd5, 4'd10, 4'd7, 4'd14, 4'd15, 4'd13, 4'd9
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Single multiply by alpha: shift left and reduce when the top bit falls out.
    function automatic logic [SYM_W-1:0] mul_alpha(input logic [SYM_W-1:0] a);
        return {a[SYM_W-2:0], 1'b0} ^ (a[SYM_W-1] ? GF_POLY : 4'b0000);
    endfunction

endpackage

// File: rtl/gf_mult_alpha_pow.sv
// Combinational multiply of a GF(16) element by the constant alpha^POW.
module gf_mult_alpha_pow
    import rs_gf16_pkg::*;
#(
    parameter int unsigned POW = 1
) (
    input  logic [SYM_W-1:0] a_i,
    output logic [SYM_W-1:0] p_o
);

    // Apply the alpha step POW times; unrolls into a small XOR network.
    always_comb begin
        p_o = a_i;
        for (int unsigned k = 0; k < POW; k++) begin
            p_o = mul_alpha(p_o);
        end
    end

endmodule

// File: rtl/rs_syndrome_ctrl.sv
// Syndrome sequencer for RS(15,11): serial symbol intake, four Horner accumulators,
// and a held result with handshake toward the key-equation stage.
module rs_syndrome_ctrl
    import rs_gf16_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [SYM_W-1:0]       SYM_IN,
    output logic                   SYN_VALID,
    input  logic                   SYN_READY,
    output logic [N_SYN*SYM_W-1:0] SYN_OUT,
    output logic                   ERR_DET,
    output logic [3:0]             SYM_CNT
);

    localparam logic [3:0] LAST_CNT = 4'(N_SYM - 1);

    state_e                          state_q, state_d;
    logic [N_SYN-1:0][SYM_W-1:0]     syn_q, syn_d;
    logic [3:0]                      cnt_q, cnt_d;
    logic                            err_q, err_d;

    logic [SYM_W-1:0]                mul_out [N_SYN];
    logic [N_SYN-1:0][SYM_W-1:0]     syn_acc;
    logic                            in_ready;
    logic                            accept;

    // S_j uses alpha^j, j = 1..N_SYN.
    for (genvar j = 0; j < N_SYN; j++) begin : g_mult
        gf_mult_alpha_pow #(
            .POW(j + 1)
        ) u_mult (
            .a_i(syn_q[j]),
            .p_o(mul_out[j])
        );
    end

    // Horner step for every accumulator.
    always_comb begin
        syn_acc = '0;
        for (int j = 0; j < N_SYN; j++) begin
            syn_acc[j] = mul_out[j] ^ SYM_IN;
        end
    end

    assign in_ready = (state_q != DONE) && !RST;
    assign accept   = IN_VALID && in_ready;

    // Next-state logic for FSM, frame counter, accumulators and error flag.
    always_comb begin
        state_d = state_q;
        syn_d   = syn_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // Accumulators are zero here, so loading equals the Horner step.
                    for (int j = 0; j < N_SYN; j++) begin
                        syn_d[j] = SYM_IN;
                    end
                    cnt_d   = 4'd1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    syn_d = syn_acc;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = 4'd0;
                        err_d   = |syn_acc;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            DONE: begin
                if (SYN_READY) begin
                    syn_d   = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                syn_d   = '0;
                cnt_d   = 4'd0;
                err_d   = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset discarding any partial or held frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            syn_q   <= '0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            syn_q   <= syn_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign IN_READY  = in_ready;
    assign SYN_VALID = (state_q == DONE);
    assign SYN_OUT   = syn_q;
    assign ERR_DET   = err_q;
    assign SYM_CNT   = cnt_q;

endmodule

// File: tb/tb_rs_syndrome_ctrl.sv
// Directed self-checking bench for rs_syndrome_ctrl.
module tb_rs_syndrome_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [3:0]  SYM_IN;
    logic        SYN_VALID;
    logic        SYN_READY;
    logic [15:0] SYN_OUT;
    logic        ERR_DET;
    logic [3:0]  SYM_CNT;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    rs_syndrome_ctrl dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .SYM_IN   (SYM_IN),
        .SYN_VALID(SYN_VALID),
        .SYN_READY(SYN_READY),
        .SYN_OUT  (SYN_OUT),
        .ERR_DET  (ERR_DET),
        .SYM_CNT  (SYM_CNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One accepted beat; returns 1 time unit after the accepting edge.
    task automatic drive_beat(input logic [3:0] s);
        IN_VALID = 1'b1;
        SYM_IN   = s;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        SYM_IN   = 4'h0;
    endtask

    task automatic idle_cycle();
        IN_VALID = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    // Full frame: r14 = first_sym, r0 = last_sym, everything between zero.
    task automatic run_frame(input logic [3:0] first_sym, input logic [3:0] last_sym);
        drive_beat(first_sym);
        for (int i = 1; i < 14; i++) drive_beat(4'h0);
        drive_beat(last_sym);
    endtask

    task automatic test_reset();
        RST = 1'b1; IN_VALID = 1'b0; SYM_IN = 4'h0; SYN_READY = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        checks++;
        if (IN_READY !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", IN_READY);
        end
        checks++;
        if (SYN_VALID !== 1'b0 || ERR_DET !== 1'b0 || SYN_OUT !== 16'h0000 || SYM_CNT !== 4'd0)
        begin
            errors++;
            $display("FAIL reset_state: valid=%b err=%b out=%h cnt=%0d want 0/0/0000/0",
                     SYN_VALID, ERR_DET, SYN_OUT, SYM_CNT);
        end
        RST = 1'b0;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++; $display("FAIL idle_in_ready: got %b want 1", IN_READY);
        end
    endtask

    task automatic test_all_zero();
        SYN_READY = 1'b1;
        for (int i = 0; i < 14; i++) drive_beat(4'h0);
        checks++;
        if (SYN_VALID !== 1'b0 || SYM_CNT !== 4'd14) begin
            errors++;
            $display("FAIL zero_pre_last: valid=%b cnt=%0d want 0/14", SYN_VALID, SYM_CNT);
        end
        drive_beat(4'h0);
        checks++;
        if (SYN_VALID !== 1'b1 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: valid=%b in_ready=%b want 1/0", SYN_VALID, IN_READY);
        end
        checks++;
        if (SYN_OUT !== 16'h0000 || ERR_DET !== 1'b0 || SYM_CNT !== 4'd0) begin
            errors++;
            $display("FAIL zero_result: out=%h err=%b cnt=%0d want 0000/0/0",
                     SYN_OUT, ERR_DET, SYM_CNT);
        end
        idle_cycle();
        checks++;
        if (IN_READY !== 1'b1 || SYN_VALID !== 1'b0) begin
            errors++;
            $display("FAIL zero_bubble: in_ready=%b valid=%b want 1/0", IN_READY, SYN_VALID);
        end
    endtask

    task automatic test_r14_one();
        SYN_READY = 1'b1;
        run_frame(4'h1, 4'h0);
        checks++;
        if (SYN_VALID !== 1'b1 || SYN_OUT !== 16'hEFD9 || ERR_DET !== 1'b1) begin
            errors++;
            $display("FAIL r14_result: valid=%b out=%h err=%b want 1/efd9/1",
                     SYN_VALID, SYN_OUT, ERR_DET);
        end
        idle_cycle();
        checks++;
        if (SYN_OUT !== 16'h0000 || SYN_VALID !== 1'b0) begin
            errors++;
            $display("FAIL r14_cleared: out=%h valid=%b want 0000/0", SYN_OUT, SYN_VALID);
        end
    endtask

    task automatic test_r0_gaps();
        SYN_READY = 1'b1;
        run_frame(4'h0, 4'h5);
        checks++;
        if (SYN_OUT !== 16'h5555 || ERR_DET !== 1'b1) begin
            errors++;
            $display("FAIL r0_result: out=%h err=%b want 5555/1", SYN_OUT, ERR_DET);
        end
        idle_cycle();
        for (int b = 1; b <= 15; b++) begin
            drive_beat((b == 15) ? 4'h5 : 4'h0);
            if (b == 4 || b == 10) begin
                for (int g = 0; g < 3; g++) begin
                    idle_cycle();
                    checks++;
                    if (SYM_CNT !== 4'(b)) begin
                        errors++;
                        $display("FAIL gap_cnt_hold: cnt=%0d want %0d", SYM_CNT, b);
                    end
                end
            end
        end
        checks++;
        if (SYN_VALID !== 1'b1 || SYN_OUT !== 16'h5555 || ERR_DET !== 1'b1) begin
            errors++;
            $display("FAIL gap_result: valid=%b out=%h err=%b want 1/5555/1",
                     SYN_VALID, SYN_OUT, ERR_DET);
        end
        idle_cycle();
    endtask

    task automatic test_stall();
        SYN_READY = 1'b0;
        run_frame(4'h1, 4'h0);
        for (int i = 0; i < 6; i++) begin
            IN_VALID = 1'b1;
            SYM_IN   = 4'(i + 7);
            @(posedge CLK); #1;
            checks++;
            if (SYN_VALID !== 1'b1 || IN_READY !== 1'b0 || SYN_OUT !== 16'hEFD9 ||
                SYM_CNT !== 4'd0) begin
                errors++;
                $display("FAIL stall_hold: valid=%b in_ready=%b out=%h cnt=%0d want 1/0/efd9/0",
                         SYN_VALID, IN_READY, SYN_OUT, SYM_CNT);
            end
        end
        SYN_READY = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        checks++;
        if (SYN_VALID !== 1'b0 || IN_READY !== 1'b1 || SYN_OUT !== 16'h0000) begin
            errors++;
            $display("FAIL stall_release: valid=%b in_ready=%b out=%h want 0/1/0000",
                     SYN_VALID, IN_READY, SYN_OUT);
        end
        run_frame(4'h0, 4'h0);
        checks++;
        if (SYN_VALID !== 1'b1 || SYN_OUT !== 16'h0000 || ERR_DET !== 1'b0) begin
            errors++;
            $display("FAIL stall_next: valid=%b out=%h err=%b want 1/0000/0",
                     SYN_VALID, SYN_OUT, ERR_DET);
        end
        idle_cycle();
    endtask

    task automatic test_mid_reset();
        int pulses;
        SYN_READY = 1'b1;
        drive_beat(4'h1);
        for (int i = 1; i < 7; i++) drive_beat(4'h3);
        RST = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready: got %b want 0", IN_READY);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        checks++;
        if (SYM_CNT !== 4'd0 || SYN_VALID !== 1'b0 || SYN_OUT !== 16'h0000) begin
            errors++;
            $display("FAIL rst_cleared: cnt=%0d valid=%b out=%h want 0/0/0000",
                     SYM_CNT, SYN_VALID, SYN_OUT);
        end
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            drive_beat(4'h0);
            if (SYN_VALID === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL rst_no_pulse: early valid count %0d want 0", pulses);
        end
        drive_beat(4'h0);
        checks++;
        if (SYN_VALID !== 1'b1 || SYN_OUT !== 16'h0000 || ERR_DET !== 1'b0) begin
            errors++;
            $display("FAIL rst_next: valid=%b out=%h err=%b want 1/0000/0",
                     SYN_VALID, SYN_OUT, ERR_DET);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        SYN_READY = 1'b1;
        run_frame(4'h1, 4'h0);
        t1 = cyc;
        checks++;
        if (SYN_VALID !== 1'b1 || SYN_OUT !== 16'hEFD9) begin
            errors++;
            $display("FAIL b2b_first: valid=%b out=%h want 1/efd9", SYN_VALID, SYN_OUT);
        end
        // Garbage offered during DONE must be ignored.
        IN_VALID = 1'b1;
        SYM_IN   = 4'hF;
        @(posedge CLK); #1;
        run_frame(4'h0, 4'h5);
        t2 = cyc;
        checks++;
        if (SYN_VALID !== 1'b1 || SYN_OUT !== 16'h5555 || ERR_DET !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: valid=%b out=%h err=%b want 1/5555/1",
                     SYN_VALID, SYN_OUT, ERR_DET);
        end
        checks++;
        if (t2 - t1 != 16) begin
            errors++; $display("FAIL b2b_spacing: got %0d cycles want 16", t2 - t1);
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_r14_one();
        test_r0_gaps();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
